// File: rtl/ext_mem_responder.sv
// ext_mem_responder: byte memory slave for a two-channel master port with fixed read/write latency and masked writes
module ext_mem_responder #(
  parameter int BASE_ADDR       = 0,
  parameter int MEMSIZE         = 256,
  parameter int MEM_DELAY_READ  = 2,
  parameter int MEM_DELAY_WRITE = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  Mout_oe_ram,
  input  logic [1:0]  Mout_we_ram,
  input  logic [15:0] Mout_addr_ram,
  input  logic [15:0] Mout_Wdata_ram,
  input  logic [7:0]  Mout_data_ram_size,
  input  logic        load_en,
  input  logic [7:0]  load_addr,
  input  logic [7:0]  load_data,
  output logic [15:0] M_Rdata_ram,
  output logic [1:0]  M_DataRdy,
  output logic        err_conflict
);
  localparam int AW = MEMSIZE > 1 ? $clog2(MEMSIZE) : 1;
  localparam int MAXD = MEM_DELAY_READ > MEM_DELAY_WRITE ? MEM_DELAY_READ : MEM_DELAY_WRITE;
  localparam int CW = $clog2(MAXD + 1);
  localparam int PD = MEM_DELAY_READ > 1 ? MEM_DELAY_READ - 1 : 1;
  logic [7:0] mem [MEMSIZE];
  logic [AW-1:0] idx [2];
  logic [7:0] wval [2];
  logic [1:0] cmt;
  logic load_ok, load_hit;
  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic [7:0] addr, wdata, mask, cur;
    logic [3:0] size;
    logic hit, rd, wr, rdy;
    logic [CW-1:0] cnt;
    logic [7:0] pipe [PD];
    assign addr = Mout_addr_ram[8*c +: 8];
    assign wdata = Mout_Wdata_ram[8*c +: 8];
    assign size = Mout_data_ram_size[4*c +: 4];
    assign hit = int'(addr) >= BASE_ADDR && int'(addr) < BASE_ADDR + MEMSIZE;
    assign idx[c] = AW'(addr - 8'(BASE_ADDR));
    assign cur = hit ? mem[idx[c]] : 8'd0;
    assign rd = reset && hit && Mout_oe_ram[c] && !Mout_we_ram[c];
    assign wr = reset && hit && Mout_we_ram[c] && !Mout_oe_ram[c];
    assign rdy = rd ? cnt == CW'(MEM_DELAY_READ - 1) : wr && cnt == CW'(MEM_DELAY_WRITE - 1);
    assign mask = ~(8'hFF << size);
    assign wval[c] = (wdata & mask) | (cur & ~mask);
    assign cmt[c] = wr && rdy;
    assign M_DataRdy[c] = rdy;
    assign M_Rdata_ram[8*c +: 8] = rd && rdy ? (MEM_DELAY_READ == 1 ? cur : pipe[PD-1]) : 8'd0;
    always_ff @(posedge clock or negedge reset)
      if (!reset) cnt <= '0;
      else cnt <= (rd || wr) && !rdy ? cnt + CW'(1) : '0;
    always_ff @(posedge clock) begin
      pipe[0] <= cur;
      for (int k = 1; k < PD; k++) pipe[k] <= pipe[k-1];
    end
  end
  assign load_ok = load_en && int'(load_addr) < MEMSIZE;
  assign load_hit = load_ok && ((cmt[0] && idx[0] == AW'(load_addr)) || (cmt[1] && idx[1] == AW'(load_addr)));
  always_ff @(posedge clock) begin
    for (int i = 0; i < 2; i++)
      if (cmt[i]) mem[idx[i]] <= wval[i];
    if (load_ok) mem[AW'(load_addr)] <= load_data;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) err_conflict <= 1'b0;
    else err_conflict <= err_conflict || load_hit || |(Mout_oe_ram & Mout_we_ram);
endmodule

// File: tb/tb_ext_mem_responder.sv
// tb_ext_mem_responder: randomized and directed checks of ext_mem_responder against a transaction-level model
module tb_ext_mem_responder;
  localparam int RD_A = 2;
  localparam int WR_A = 1;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset_a, reset_b;
  logic [1:0] oe_a, we_a, oe_b, we_b;
  logic [15:0] addr_a, wdata_a, addr_b, wdata_b;
  logic [7:0] size_a, size_b;
  logic load_en_a, load_en_b;
  logic [7:0] load_addr_a, load_data_a, load_addr_b, load_data_b;
  logic [15:0] rdata_a, rdata_b;
  logic [1:0] rdy_a, rdy_b;
  logic err_a, err_b;
  int vectors = 0;
  int miscompares = 0;
  logic [7:0] m_mem [256];
  bit m_run [2];
  int m_start [2];
  logic [7:0] m_snap [2];
  bit m_err;
  int cyc;
  int hold [2];
  bit gap [2];
  ext_mem_responder dut_a (
    .clock(clock), .reset(reset_a), .Mout_oe_ram(oe_a), .Mout_we_ram(we_a),
    .Mout_addr_ram(addr_a), .Mout_Wdata_ram(wdata_a), .Mout_data_ram_size(size_a),
    .load_en(load_en_a), .load_addr(load_addr_a), .load_data(load_data_a),
    .M_Rdata_ram(rdata_a), .M_DataRdy(rdy_a), .err_conflict(err_a)
  );
  ext_mem_responder #(.BASE_ADDR(64), .MEMSIZE(16), .MEM_DELAY_READ(4), .MEM_DELAY_WRITE(2)) dut_b (
    .clock(clock), .reset(reset_b), .Mout_oe_ram(oe_b), .Mout_we_ram(we_b),
    .Mout_addr_ram(addr_b), .Mout_Wdata_ram(wdata_b), .Mout_data_ram_size(size_b),
    .load_en(load_en_b), .load_addr(load_addr_b), .load_data(load_data_b),
    .M_Rdata_ram(rdata_b), .M_DataRdy(rdy_b), .err_conflict(err_b)
  );
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [7:0] merge(input logic [7:0] old, input logic [7:0] data, input int size);
    int mask;
    mask = size >= 8 ? 255 : (1 << size) - 1;
    return 8'((int'(data) & mask) | (int'(old) & ~mask));
  endfunction
  task automatic next();
    @(posedge clock);
    #1;
  endtask
  task automatic eval_a();
    logic [1:0] e_rdy;
    logic [15:0] e_rd;
    logic [7:0] a [2];
    logic [7:0] nv [2];
    @(negedge clock);
    e_rdy = 2'b00;
    e_rd = 16'h0;
    if (!reset_a) begin
      m_err = 1'b0;
      m_run[0] = 1'b0;
      m_run[1] = 1'b0;
    end
    for (int c = 0; c < 2; c++) begin
      a[c] = addr_a[8*c +: 8];
      nv[c] = merge(m_mem[a[c]], wdata_a[8*c +: 8], int'(size_a[4*c +: 4]));
      if (!reset_a || oe_a[c] == we_a[c]) m_run[c] = 1'b0;
      else begin
        if (!m_run[c]) begin
          m_run[c] = 1'b1;
          m_start[c] = cyc;
          m_snap[c] = m_mem[a[c]];
        end
        if (cyc - m_start[c] == (oe_a[c] ? RD_A : WR_A) - 1) begin
          e_rdy[c] = 1'b1;
          m_run[c] = 1'b0;
          if (oe_a[c]) e_rd[8*c +: 8] = m_snap[c];
        end
      end
    end
    check("rdy_a", 16'(rdy_a), 16'(e_rdy));
    check("rdata_a", rdata_a, e_rd);
    check("err_a", 16'(err_a), 16'(m_err));
    if (reset_a) begin
      for (int c = 0; c < 2; c++)
        if (e_rdy[c] && we_a[c]) m_mem[a[c]] = nv[c];
      if (load_en_a) begin
        for (int c = 0; c < 2; c++)
          if (e_rdy[c] && we_a[c] && a[c] == load_addr_a) m_err = 1'b1;
        m_mem[load_addr_a] = load_data_a;
      end
      if ((oe_a & we_a) != 2'b00) m_err = 1'b1;
    end
    cyc++;
  endtask
  task automatic step_a();
    eval_a();
    next();
  endtask
  task automatic set_a(input int c, input bit oe, input bit we, input logic [7:0] ad, input logic [7:0] d, input logic [3:0] sz);
    oe_a[c] = oe;
    we_a[c] = we;
    addr_a[8*c +: 8] = ad;
    wdata_a[8*c +: 8] = d;
    size_a[4*c +: 4] = sz;
  endtask
  task automatic set_b(input int c, input bit oe, input bit we, input logic [7:0] ad, input logic [7:0] d, input logic [3:0] sz);
    oe_b[c] = oe;
    we_b[c] = we;
    addr_b[8*c +: 8] = ad;
    wdata_b[8*c +: 8] = d;
    size_b[4*c +: 4] = sz;
  endtask
  task automatic drive_rand();
    for (int c = 0; c < 2; c++) begin
      if (hold[c] != 0) hold[c]--;
      else begin
        oe_a[c] = 1'b0;
        we_a[c] = 1'b0;
        if (gap[c]) gap[c] = 1'b0;
        else if ($urandom_range(3) != 0) begin
          bit w;
          int n;
          w = 1'($urandom_range(1));
          n = w ? int'($urandom_range(3, 1)) : 2 * int'($urandom_range(3, 1));
          if (!w && $urandom_range(5) == 0) begin
            n = 1;
            gap[c] = 1'b1;
          end
          set_a(c, !w, w, 8'(w ? $urandom_range(15) : $urandom_range(31)), 8'($urandom), 4'($urandom_range(8)));
          hold[c] = n - 1;
        end
      end
    end
    load_en_a = ($urandom_range(7) == 0);
    load_addr_a = 8'(16 + $urandom_range(15));
    load_data_a = 8'($urandom);
  endtask
  initial begin
    reset_a = 1'b0; reset_b = 1'b0;
    oe_a = '0; we_a = '0; addr_a = '0; wdata_a = '0; size_a = '0;
    oe_b = '0; we_b = '0; addr_b = '0; wdata_b = '0; size_b = '0;
    load_en_a = 1'b0; load_addr_a = '0; load_data_a = '0;
    load_en_b = 1'b0; load_addr_b = '0; load_data_b = '0;
    cyc = 0; m_err = 1'b0;
    m_run[0] = 1'b0; m_run[1] = 1'b0;
    hold[0] = 0; hold[1] = 0; gap[0] = 1'b0; gap[1] = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    set_a(0, 1'b1, 1'b0, 8'd1, 8'd0, 4'd0);
    set_b(0, 1'b1, 1'b0, 8'h40, 8'd0, 4'd0);
    eval_a();
    check("rst_rdy_b", 16'(rdy_b), 16'h0);
    check("rst_rdata_b", rdata_b, 16'h0);
    check("rst_err_b", 16'(err_b), 16'h0);
    next();
    set_a(0, 1'b0, 1'b0, 8'd0, 8'd0, 4'd0);
    set_b(0, 1'b0, 1'b0, 8'd0, 8'd0, 4'd0);
    reset_a = 1'b1; reset_b = 1'b1;
    for (int i = 0; i < 256; i++) begin
      load_en_a = 1'b1;
      load_addr_a = 8'(i);
      load_data_a = 8'($urandom);
      step_a();
    end
    load_en_a = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      drive_rand();
      step_a();
    end
    set_a(0, 1'b0, 1'b0, 8'd0, 8'd0, 4'd0);
    set_a(1, 1'b0, 1'b0, 8'd0, 8'd0, 4'd0);
    load_en_a = 1'b0;
    step_a();
    load_en_a = 1'b1; load_addr_a = 8'd5; load_data_a = 8'hA7;
    step_a();
    load_en_a = 1'b0;
    set_a(0, 1'b1, 1'b0, 8'd5, 8'd0, 4'd0);
    eval_a(); check("rd_lat_c0", 16'(rdy_a[0]), 16'h0); next();
    eval_a(); check("rd_lat_c1", 16'(rdy_a[0]), 16'h1); check("rd_data", 16'(rdata_a[7:0]), 16'hA7); next();
    set_a(0, 1'b0, 1'b0, 8'd0, 8'd0, 4'd0);
    eval_a(); check("rd_drop_rdy", 16'(rdy_a), 16'h0); check("rd_drop_data", rdata_a, 16'h0); next();
    load_en_a = 1'b1; load_addr_a = 8'd3; load_data_a = 8'hFF;
    step_a();
    load_en_a = 1'b0;
    set_a(1, 1'b0, 1'b1, 8'd3, 8'h00, 4'd4);
    eval_a(); check("mw_rdy", 16'(rdy_a[1]), 16'h1); next();
    set_a(1, 1'b0, 1'b1, 8'd3, 8'h55, 4'd0);
    eval_a(); check("sz0_rdy", 16'(rdy_a[1]), 16'h1); next();
    set_a(1, 1'b0, 1'b0, 8'd0, 8'd0, 4'd0);
    set_a(0, 1'b1, 1'b0, 8'd3, 8'd0, 4'd0);
    step_a();
    eval_a(); check("mw_data", 16'(rdata_a[7:0]), 16'hF0); next();
    set_a(0, 1'b0, 1'b1, 8'd9, 8'h11, 4'd8);
    set_a(1, 1'b0, 1'b1, 8'd9, 8'h22, 4'd8);
    step_a();
    set_a(1, 1'b0, 1'b0, 8'd0, 8'd0, 4'd0);
    set_a(0, 1'b1, 1'b0, 8'd9, 8'd0, 4'd0);
    step_a();
    set_a(1, 1'b0, 1'b1, 8'd9, 8'h33, 4'd8);
    eval_a(); check("wcol_data", 16'(rdata_a[7:0]), 16'h22); check("wcol_err", 16'(err_a), 16'h0); next();
    set_a(1, 1'b0, 1'b0, 8'd0, 8'd0, 4'd0);
    step_a();
    eval_a(); check("rw_new_data", 16'(rdata_a[7:0]), 16'h33); next();
    set_a(0, 1'b0, 1'b1, 8'd7, 8'hC3, 4'd8);
    load_en_a = 1'b1; load_addr_a = 8'd7; load_data_a = 8'h5A;
    step_a();
    load_en_a = 1'b0;
    set_a(0, 1'b1, 1'b0, 8'd7, 8'd0, 4'd0);
    eval_a(); check("ld_col_err", 16'(err_a), 16'h1); next();
    eval_a(); check("ld_col_data", 16'(rdata_a[7:0]), 16'h5A); next();
    reset_a = 1'b0;
    eval_a(); check("rst_err_a", 16'(err_a), 16'h0); next();
    reset_a = 1'b1;
    set_a(0, 1'b1, 1'b1, 8'd4, 8'd0, 4'd8);
    eval_a(); check("cf_err0", 16'(err_a), 16'h0); check("cf_rdy0", 16'(rdy_a[0]), 16'h0); next();
    eval_a(); check("cf_err1", 16'(err_a), 16'h1); check("cf_rdy1", 16'(rdy_a[0]), 16'h0); next();
    eval_a(); check("cf_rdy2", 16'(rdy_a[0]), 16'h0); next();
    set_a(0, 1'b0, 1'b0, 8'd0, 8'd0, 4'd0);
    repeat (3) step_a();
    check("cf_sticky", 16'(err_a), 16'h1);
    for (int i = 0; i < 16; i++) begin
      load_en_b = 1'b1; load_addr_b = 8'(i); load_data_b = 8'(8'hB0 + i);
      next();
    end
    load_addr_b = 8'd16; load_data_b = 8'hEE;
    next();
    load_en_b = 1'b0;
    set_b(0, 1'b1, 1'b0, 8'h3F, 8'd0, 4'd0);
    set_b(1, 1'b1, 1'b0, 8'h50, 8'd0, 4'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("rng_rdy", 16'(rdy_b), 16'h0);
      check("rng_data", rdata_b, 16'h0);
      next();
    end
    set_b(1, 1'b0, 1'b0, 8'd0, 8'd0, 4'd0);
    set_b(0, 1'b1, 1'b0, 8'h4F, 8'd0, 4'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("top_rdy", 16'(rdy_b[0]), 16'(i == 3));
      if (i == 3) check("top_data", 16'(rdata_b[7:0]), 16'hBF);
      next();
    end
    set_b(0, 1'b1, 1'b0, 8'h40, 8'd0, 4'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (i == 3) check("ld_oob_data", 16'(rdata_b[7:0]), 16'hB0);
      next();
    end
    set_b(0, 1'b0, 1'b0, 8'd0, 8'd0, 4'd0);
    set_b(1, 1'b0, 1'b1, 8'h40, 8'h12, 4'd8);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      check("wr_b_rdy", 16'(rdy_b[1]), 16'(i == 1));
      next();
    end
    set_b(1, 1'b0, 1'b0, 8'd0, 8'd0, 4'd0);
    set_b(0, 1'b1, 1'b0, 8'h40, 8'd0, 4'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (i == 3) check("wr_b_data", 16'(rdata_b[7:0]), 16'h12);
      next();
    end
    set_b(0, 1'b0, 1'b0, 8'd0, 8'd0, 4'd0);
    next();
    set_b(0, 1'b1, 1'b0, 8'h45, 8'd0, 4'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      check("mid_pre_rdy", 16'(rdy_b), 16'h0);
      next();
    end
    reset_b = 1'b0;
    #1;
    check("mid_rst_rdy", 16'(rdy_b), 16'h0);
    check("mid_rst_data", rdata_b, 16'h0);
    next();
    reset_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("mid_post_rdy", 16'(rdy_b[0]), 16'(i == 3));
      if (i == 3) check("mid_post_data", 16'(rdata_b[7:0]), 16'hB5);
      next();
    end
    set_b(0, 1'b1, 1'b0, 8'h46, 8'd0, 4'd0);
    repeat (3) next();
    @(negedge clock);
    check("async_pre_rdy", 16'(rdy_b[0]), 16'h1);
    check("async_pre_data", 16'(rdata_b[7:0]), 16'hB6);
    #2;
    reset_b = 1'b0;
    #1;
    check("async_rdy", 16'(rdy_b), 16'h0);
    check("async_data", rdata_b, 16'h0);
    next();
    reset_b = 1'b1;
    set_b(0, 1'b0, 1'b0, 8'd0, 8'd0, 4'd0);
    @(negedge clock);
    check("err_b", 16'(err_b), 16'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ext_mem_responder.md
Name: ext_mem_responder

Overview:
- Synthesizable off-chip memory slave for a Bambu-generated accelerator's two-channel master port (Mout_*).
- Sits directly downstream of that port: stores bytes, applies size-masked writes, and answers reads and writes with parameterised latency through M_Rdata_ram and M_DataRdy.
- Replaces the behavioural memory model so on-target and co-simulation runs use identical timing.
- Includes a preload port used by the value loader before start_port is raised.

Parameters:
- BASE_ADDR, 0: first byte address owned by this block.
- MEMSIZE, 256: number of bytes owned; the valid range is BASE_ADDR <= addr < BASE_ADDR+MEMSIZE, with MEMSIZE <= 256.
- MEM_DELAY_READ, 2: read latency in cycles; must be >= 1.
- MEM_DELAY_WRITE, 1: write latency in cycles; must be >= 1.

Ports:
- clock  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- Mout_oe_ram  in  2  read request, one bit per channel.
- Mout_we_ram  in  2  write request, one bit per channel.
- Mout_addr_ram  in  16  byte address; channel c uses bits [8c+7:8c].
- Mout_Wdata_ram  in  16  write data; channel c uses bits [8c+7:8c].
- Mout_data_ram_size  in  8  access width in bits; channel c uses bits [4c+3:4c], valid values 0..8.
- load_en  in  1  preload write strobe.
- load_addr  in  8  preload address, offset from BASE_ADDR.
- load_data  in  8  preload byte.
- M_Rdata_ram  out  16  read data per channel; 0 when that channel's DataRdy is low.
- M_DataRdy  out  2  per-channel completion pulse.
- err_conflict  out  1  sticky error flag.

Behaviour:
- Reset (reset=0, asynchronous): per-channel counters=0, M_DataRdy=0, M_Rdata_ram=0, err_conflict=0. Memory contents are not reset.
- Reset mid-access: the outstanding access is dropped; the master must reissue it.
- In range: a channel is in range when its address falls in [BASE_ADDR, BASE_ADDR+MEMSIZE). Out-of-range requests are ignored entirely: counter held at 0, DataRdy=0, Rdata=0, no write.
- Master obligation: hold oe/we, address, data and size stable from the first request cycle until the cycle DataRdy=1 (inclusive).
- Per-channel counter cnt:
  - While an in-range request is held, cnt increments each cycle.
  - DataRdy[c]=1 combinationally when cnt==DELAY-1, where DELAY is MEM_DELAY_READ for reads and MEM_DELAY_WRITE for writes.
  - On the DataRdy cycle cnt returns to 0.
  - If the request drops early, cnt returns to 0.
  - A request still held after DataRdy is a new back-to-back access.
- Read data path:
  - A registered read pipeline of depth MEM_DELAY_READ-1 follows the address.
  - On the DataRdy cycle, Rdata[c] = mem[addr-BASE_ADDR] as sampled MEM_DELAY_READ-1 cycles earlier.
  - For MEM_DELAY_READ=1, Rdata is combinational.
- Write data path:
  - The write commits on the rising edge that ends the DataRdy cycle.
  - Committed value: mem = (Wdata & mask) | (mem & ~mask), with mask = (1<<size)-1 truncated to 8 bits.
  - size=0 gives no change but still completes; size>=8 gives a full byte.
- Same-cycle collisions:
  - Two channels writing the same address on the same edge: channel 1 wins.
  - A read completing on the edge a write to the same address commits: the read returns the old data.
- Preload port:
  - load_en writes mem[load_addr] unmasked on the edge.
  - load_addr >= MEMSIZE is ignored.
  - If load and a channel write target the same byte on the same edge, the load wins and err_conflict is set.
- err_conflict:
  - Set on any edge where oe[c]&we[c] for a channel; that channel's request is ignored for that cycle and cnt is cleared.
  - Also set on a load/channel-write collision (above).
  - Cleared only by reset.
- Channels are fully independent apart from the collision rules above.

Test Plan:
- Read latency: preload mem[5]=0xA7; ch0 oe=1, addr=5, MEM_DELAY_READ=2 -> DataRdy[0]=0 in cycle 0, =1 in cycle 1 with Rdata[7:0]=0xA7, then 0 when oe drops.
- Masked write: mem[3]=0xFF; ch1 we=1, addr=3, Wdata=0x00, size=4, MEM_DELAY_WRITE=1 -> DataRdy[1]=1 in the same cycle; subsequent read of addr 3 returns 0xF0.
- Range check: BASE_ADDR=0x40, MEMSIZE=16; oe at addr 0x3F and at 0x50 -> no DataRdy, Rdata=0 for 10 cycles. Addr 0x4F -> responds normally.
- Write collision: both channels write addr 9 (ch0 0x11, ch1 0x22) on the same edge -> mem[9]=0x22, err_conflict stays 0.
- Conflict flag: ch0 oe=1 and we=1 together -> err_conflict=1 next cycle and stays 1, no DataRdy[0]. Preload/ch0-write collision on the same byte -> load value stored.
- Reset mid-access: MEM_DELAY_READ=4, oe held, reset pulsed low in cycle 2 -> DataRdy=0 and Rdata=0 immediately. After release, the held request completes 4 cycles later.
